// File: rtl/sram_burst_master.sv
// Burst engine: one command becomes consecutive accesses on a single-port SRAM.
// Define SRAM_BURST_BOUND_CHECK_EN to reject bursts that run past the top word.
module sram_burst_master #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 1024,
  parameter int LEN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 2,
  localparam int AW = $clog2(NUM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic [AW-1:0]         cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] wbe_i,
  output logic                  rdata_valid_o,
  input  logic                  rdata_ready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_last_o,
  output logic                  busy_o,
`ifdef SRAM_BURST_BOUND_CHECK_EN
  output logic                  cmd_err_o,
`endif
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [DATA_WIDTH-1:0] sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN
  } state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [AW-1:0]         r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_beat;
  logic                  r_inflight;
  logic                  r_infl_last;
  logic [DATA_WIDTH-1:0] r_fifo_q [FIFO_DEPTH];
  logic                  r_fifo_l [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  logic          w_accept;
  logic          w_oob;
  logic          w_start;
  logic          w_wr_hs;
  logic          w_rd_issue;
  logic          w_step;
  logic          w_last_beat;
  logic          w_push;
  logic          w_pop;
  logic          w_empty;
  logic [CW:0]   w_occ;
  logic [AW-1:0] w_addr_inc;

  assign w_accept    = cmd_valid_i & (r_state == S_IDLE);
  assign w_start     = w_accept & ~w_oob;
  assign w_last_beat = (r_beat == r_len);
  assign w_empty     = (r_count == '0);
  assign w_push      = r_inflight;
  assign w_pop       = ~w_empty & rdata_ready_i;
  assign w_wr_hs     = (r_state == S_WRITE) & wdata_valid_i;

  // A pop this cycle frees a slot, which keeps reads at one beat per clock.
  assign w_occ = {1'b0, r_count}
               + (CW+1)'(r_inflight)
               - (CW+1)'(w_pop);

  assign w_rd_issue = (r_state == S_READ)
                    & (w_occ < (CW+1)'(FIFO_DEPTH));
  assign w_step     = w_wr_hs | w_rd_issue;

  assign w_addr_inc = (r_addr == AW'(NUM_WORDS - 1))
                    ? '0 : r_addr + 1'b1;

`ifdef SRAM_BURST_BOUND_CHECK_EN
  localparam int SW = ((AW > LEN_WIDTH) ? AW : LEN_WIDTH) + 2;

  logic [SW-1:0] w_end;
  logic          r_err;

  assign w_end     = SW'(cmd_addr_i) + SW'(cmd_len_i);
  assign w_oob     = (w_end >= SW'(NUM_WORDS));
  assign cmd_err_o = r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept & w_oob;
    end
  end
`else
  assign w_oob = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = cmd_we_i ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (w_wr_hs && w_last_beat) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        if (w_rd_issue && w_last_beat) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!r_inflight && w_empty) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o   = 1'b0;
    wdata_ready_o = 1'b0;
    sram_req_o    = 1'b0;
    sram_we_o     = 1'b0;
    sram_addr_o   = '0;
    sram_wdata_o  = '0;
    sram_be_o     = '0;
    unique case (1'b1)
      (r_state == S_IDLE): begin
        cmd_ready_o = 1'b1;
      end
      (r_state == S_WRITE): begin
        wdata_ready_o = 1'b1;
        sram_req_o    = wdata_valid_i;
        sram_we_o     = wdata_valid_i;
        sram_addr_o   = r_addr;
        sram_wdata_o  = wdata_i;
        sram_be_o     = wbe_i;
      end
      (r_state == S_READ): begin
        sram_req_o  = w_rd_issue;
        sram_addr_o = r_addr;
      end
      default: begin
        sram_req_o = 1'b0;
      end
    endcase
  end

  assign busy_o        = (r_state != S_IDLE);
  assign rdata_valid_o = ~w_empty;
  assign rdata_o       = w_empty ? '0 : r_fifo_q[r_rptr];
  assign rdata_last_o  = ~w_empty & r_fifo_l[r_rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_inflight  <= w_rd_issue;
      r_infl_last <= w_rd_issue & w_last_beat;
      if (w_start) begin
        r_addr <= cmd_addr_i;
        r_len  <= cmd_len_i;
        r_beat <= '0;
      end else if (w_step) begin
        r_addr <= w_addr_inc;
        r_beat <= r_beat + 1'b1;
      end
    end
  end

  // Return buffer: the SRAM word arriving one cycle after issue is always pushed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_q[i] <= '0;
        r_fifo_l[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifo_q[r_wptr] <= sram_rdata_i;
        r_fifo_l[r_wptr] <= r_infl_last;
        r_wptr           <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_sram_burst_master.sv
// Directed bench for sram_burst_master with a behavioural SRAM.
// Expected values are hand-derived constants per scenario.
module tb_sram_burst_master;
  localparam int DW = 64;
  localparam int NW = 1024;
  localparam int LW = 8;
  localparam int FD = 2;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wdata_valid, wdata_ready;
  logic [DW-1:0] wdata, wbe;
  logic          rdata_valid, rdata_ready, rdata_last;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_be, sram_rdata;
`ifdef SRAM_BURST_BOUND_CHECK_EN
  logic          cmd_err;
`endif

  always #5 clk = ~clk;

  sram_burst_master #(
    .DATA_WIDTH(DW), .NUM_WORDS(NW),
    .LEN_WIDTH(LW), .FIFO_DEPTH(FD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_we_i(cmd_we), .cmd_addr_i(cmd_addr),
    .cmd_len_i(cmd_len),
    .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready),
    .wdata_i(wdata), .wbe_i(wbe),
    .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready),
    .rdata_o(rdata), .rdata_last_o(rdata_last),
    .busy_o(busy),
`ifdef SRAM_BURST_BOUND_CHECK_EN
    .cmd_err_o(cmd_err),
`endif
    .sram_req_o(sram_req), .sram_we_o(sram_we),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata),
    .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  logic [DW-1:0] mem [NW];

  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we)
        mem[sram_addr] <= (mem[sram_addr] & ~sram_be) | (sram_wdata & sram_be);
      else
        sram_rdata <= mem[sram_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [AW-1:0] q_addr [$];
  bit            q_we   [$];
  logic [DW-1:0] q_wd   [$];
  int            q_cyc  [$];
  logic [DW-1:0] r_d    [$];
  bit            r_l    [$];
  int            r_c    [$];
  int acc_cyc, n_rdreq, max_out, n_err;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (sram_req) begin
        q_addr.push_back(sram_addr);
        q_we.push_back(sram_we);
        q_wd.push_back(sram_wdata);
        q_cyc.push_back(cyc);
        if (!sram_we) n_rdreq++;
      end
      if (rdata_valid && rdata_ready) begin
        r_d.push_back(rdata);
        r_l.push_back(rdata_last);
        r_c.push_back(cyc);
      end
      if (n_rdreq - r_d.size() > max_out) max_out = n_rdreq - r_d.size();
`ifdef SRAM_BURST_BOUND_CHECK_EN
      if (cmd_err) n_err++;
`endif
    end
  end

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clr();
    q_addr.delete(); q_we.delete(); q_wd.delete(); q_cyc.delete();
    r_d.delete(); r_l.delete(); r_c.delete();
    n_rdreq = 0; max_out = 0; n_err = 0;
  endtask

  task automatic issue_cmd(input bit we, input logic [AW-1:0] a, input logic [LW-1:0] l);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = l;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // pat bit k gives wdata_valid for the k-th cycle after accept
  task automatic wr_burst(input logic [AW-1:0] a, input logic [LW-1:0] l,
                          input logic [DW-1:0] base, input logic [7:0] pat);
    int sent;
    bit hs;
    clr();
    issue_cmd(1'b1, a, l);
    sent = 0;
    for (int k = 0; k < 40 && sent <= int'(l); k++) begin
      wdata_valid = (k < 8) ? pat[k] : 1'b1;
      wdata = base + DW'(sent);
      @(negedge clk);
      hs = wdata_valid && wdata_ready;
      @(posedge clk); #1;
      if (hs) sent++;
    end
    wdata_valid = 1'b0;
    chk("wr_beats", sent, int'(l) + 1);
  endtask

  task automatic rd_burst(input logic [AW-1:0] a, input logic [LW-1:0] l, input int stall);
    int st;
    bit done;
    clr();
    rdata_ready = 1'b1;
    issue_cmd(1'b0, a, l);
    st = 0;
    done = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      if (stall > 0 && r_d.size() >= 1 && st < stall) begin
        rdata_ready = 1'b0;
        st++;
      end else begin
        rdata_ready = 1'b1;
      end
      @(posedge clk); #1;
      done = !busy && !rdata_valid;
    end
    rdata_ready = 1'b1;
    chk("rd_done", done, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0; wbe = '1;
    rdata_ready = 1'b0;
    for (int i = 0; i < NW; i++) mem[i] = '0;
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_req", sram_req, 0);
    chk("rst_wready", wdata_ready, 0);
    chk("rst_rvalid", rdata_valid, 0);
    chk("rst_rlast", rdata_last, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_rdata", rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    wr_burst(10'h010, 8'd3, 64'hA0, 8'hFF);
    chk("wr_nreq", q_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("wr_addr", q_addr[i], 64'h10 + i);
      chk("wr_we", q_we[i], 1);
      chk("wr_data", q_wd[i], 64'hA0 + i);
      chk("wr_cyc", q_cyc[i] - q_cyc[0], i);
    end
    chk("wr_idle_busy", busy, 0);
    chk("wr_idle_ready", cmd_ready, 1);

    // accept edge closes cycle A; first beat visible in cycle A+3
    rd_burst(10'h010, 8'd3, 0);
    chk("rd_nbeat", r_d.size(), 4);
    chk("rd_nreq", n_rdreq, 4);
    chk("rd_lat", r_c[0] - acc_cyc, 3);
    for (int i = 0; i < 4; i++) begin
      chk("rd_data", r_d[i], 64'hA0 + i);
      chk("rd_last", r_l[i], (i == 3) ? 1 : 0);
      chk("rd_rate", r_c[i] - r_c[0], i);
    end

    rd_burst(10'h010, 8'd3, 5);
    chk("bp_nbeat", r_d.size(), 4);
    chk("bp_nreq", n_rdreq, 4);
    chk("bp_maxout", max_out <= FD, 1);
    chk("bp_reqgap", (q_cyc[3] - q_cyc[2]) >= 6, 1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_data", r_d[i], 64'hA0 + i);
      chk("bp_last", r_l[i], (i == 3) ? 1 : 0);
    end

`ifndef SRAM_BURST_BOUND_CHECK_EN
    wr_burst(10'h3FE, 8'd2, 64'hB0, 8'hFF);
    chk("wrap_nreq", q_addr.size(), 3);
    chk("wrap_a0", q_addr[0], 64'h3FE);
    chk("wrap_a1", q_addr[1], 64'h3FF);
    chk("wrap_a2", q_addr[2], 64'h000);
    rd_burst(10'h3FE, 8'd2, 0);
    chk("wrap_nbeat", r_d.size(), 3);
    for (int i = 0; i < 3; i++) chk("wrap_rd", r_d[i], 64'hB0 + i);
`else
    clr();
    issue_cmd(1'b1, 10'h3FE, 8'd2);
    wdata_valid = 1'b1;
    wdata = 64'hB0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
    end
    wdata_valid = 1'b0;
    chk("oob_err_pulses", n_err, 1);
    chk("oob_nreq", q_addr.size(), 0);
    chk("oob_busy", busy, 0);
`endif

    wr_burst(10'h020, 8'd2, 64'hC0, 8'b0001_1001);
    chk("gap_nreq", q_addr.size(), 3);
    chk("gap_c1", q_cyc[1] - q_cyc[0], 3);
    chk("gap_c2", q_cyc[2] - q_cyc[0], 4);
    for (int i = 0; i < 3; i++) begin
      chk("gap_addr", q_addr[i], 64'h20 + i);
      chk("gap_data", q_wd[i], 64'hC0 + i);
    end

    clr();
    rdata_ready = 1'b1;
    issue_cmd(1'b0, 10'h010, 8'd7);
    for (int k = 0; k < 20 && r_d.size() < 2; k++) begin
      @(posedge clk); #1;
    end
    chk("mid_beats", r_d.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("mid_cmd_ready", cmd_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_req", sram_req, 0);
    chk("mid_rvalid", rdata_valid, 0);
    chk("mid_rlast", rdata_last, 0);
    chk("mid_addr", sram_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_rvalid", rdata_valid, 0);
    chk("post_busy", busy, 0);

    rd_burst(10'h011, 8'd0, 0);
    chk("one_nbeat", r_d.size(), 1);
    chk("one_data", r_d[0], 64'hA1);
    chk("one_last", r_l[0], 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/sram_burst_master.md
Name: sram_burst_master

Overview:
- Initiator for the single-port SRAM request interface: req/we/addr/wdata/bit-enable out, read data returned one cycle after the read request.
- Converts one burst command (start address, beat count, direction) into consecutive SRAM accesses.
- Write bursts take data from a valid/ready write stream. Read bursts return data on a valid/ready read stream.
- Reads are buffered in a small FIFO so read-stream backpressure never loses a returning SRAM word.
- Sits between a DMA/loader client and the SRAM macro wrapper.

Parameters:
- DATA_WIDTH, 64, SRAM word width in bits.
- NUM_WORDS, 1024, SRAM depth in words. AW = $clog2(NUM_WORDS).
- LEN_WIDTH, 8, width of the burst length field. Burst holds len+1 beats.
- FIFO_DEPTH, 2, read return buffer entries (≥2, power of two).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  burst command valid.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_we_i  in  1  1=write burst, 0=read burst.
- cmd_addr_i  in  AW  start word address.
- cmd_len_i  in  LEN_WIDTH  beats minus one.
- wdata_valid_i  in  1  write beat valid.
- wdata_ready_o  out  1  write beat consumed.
- wdata_i  in  DATA_WIDTH  write data.
- wbe_i  in  DATA_WIDTH  per-bit write enable.
- rdata_valid_o  out  1  read beat valid.
- rdata_ready_i  in  1  read beat consumer ready.
- rdata_o  out  DATA_WIDTH  read data.
- rdata_last_o  out  1  marks final beat of a read burst.
- busy_o  out  1  high whenever state != IDLE.
- sram_req_o  out  1  SRAM request.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  AW  SRAM word address.
- sram_wdata_o  out  DATA_WIDTH  SRAM write data.
- sram_be_o  out  DATA_WIDTH  SRAM bit enables.
- sram_rdata_i  in  DATA_WIDTH  SRAM read data, valid the cycle after a read req.

Behaviour:
- Reset values (async, rst_ni low):
  - FSM=IDLE; address, beat, FIFO and in-flight counters = 0.
  - cmd_ready_o=1.
  - All other outputs 0: busy_o, sram_req_o, sram_we_o, wdata_ready_o, rdata_valid_o, rdata_last_o; buses 0.
  - Reset mid-burst aborts it and flushes the FIFO. Nothing is replayed.
- FSM states: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - cmd_ready_o=1.
  - On accept: latch addr and len, beat counter=0, go WRITE if cmd_we_i else READ.
  - cmd_ready_o=0 in every other state.
- WRITE:
  - wdata_ready_o=1.
  - Combinationally, sram_req_o = sram_we_o = wdata_valid_i.
  - sram_wdata_o=wdata_i, sram_be_o=wbe_i, sram_addr_o=current address.
  - Each handshake: address+1 modulo NUM_WORDS (wraps NUM_WORDS-1→0), beat+1.
  - After beat len is written, next state IDLE.
  - Gaps in wdata_valid_i stall without any SRAM request.
- READ:
  - sram_req_o=1, sram_we_o=0, sram_be_o=0 only when fifo_count + inflight < FIFO_DEPTH.
  - inflight is 0/1, set the cycle a read req issues.
  - The next cycle, sram_rdata_i is pushed into the FIFO.
  - Address wraps as in WRITE.
  - After issuing beat len, go DRAIN.
- DRAIN: go IDLE once inflight==0 and FIFO is empty.
- Read stream:
  - rdata_valid_o = FIFO non-empty; rdata_o = FIFO head; pop on valid&ready.
  - rdata_last_o is stored per entry, set for beat len.
  - Push and pop in the same cycle keep the count unchanged.
  - FIFO never overflows, by the issue rule.
- Throughput:
  - Full-rate reads (1 beat/cycle) when rdata_ready_i is held high.
  - First read data appears on rdata_o 2 cycles after command accept.
- len=0 is a single-beat burst. len=2^LEN_WIDTH-1 gives the maximum burst.

Optional Feature:
- Macro: SRAM_BURST_BOUND_CHECK_EN.
- Defined:
  - Adds port cmd_err_o (out, 1).
  - A command with cmd_addr_i + cmd_len_i ≥ NUM_WORDS is accepted (cmd_ready_o handshake completes).
  - cmd_err_o pulses for one cycle, no SRAM access occurs, and the FSM stays in IDLE.
- Undefined: port absent; such bursts wrap the address modulo NUM_WORDS.

Test Plan:
- Write burst addr=0x010, len=3, data 0xA0..0xA3, wbe all-ones, no gaps → sram_req_o/sram_we_o high 4 consecutive cycles, sram_addr_o 0x010..0x013, then IDLE, busy_o low.
- Read burst addr=0x010, len=3, rdata_ready_i=1 → rdata_o 0xA0..0xA3 on 4 consecutive cycles starting 2 cycles after accept; rdata_last_o only on 0xA3.
- Same read with rdata_ready_i low for 5 cycles after the first beat → at most FIFO_DEPTH words outstanding; sram_req_o held low; no beat lost or duplicated; order preserved.
- Write addr=0x3FE, len=2 (macro undefined) → SRAM addresses 0x3FE, 0x3FF, 0x000. With macro defined → cmd_err_o one-cycle pulse, zero SRAM requests.
- Write with wdata_valid_i toggled 1,0,0,1,1 → exactly 3 SRAM writes, only on valid cycles, addresses consecutive.
- rst_ni asserted during beat 2 of a len=7 read → all outputs at reset values immediately; after release cmd_ready_o=1, rdata_valid_o=0, FIFO empty.
